// File: rtl/proc_sad_frame_ctrl.sv
// Frame sequencer for the SAD datapath: scans one frame into the datapath, drains, reports the sum.
// Optional build macro SAD_FIRST_FRAME_MASK_EN suppresses the report of the first frame after reset.
module proc_sad_frame_ctrl #(
    parameter int unsigned FRAME_LEN = 18000,
    parameter int unsigned AW        = 15,
    parameter int unsigned DW        = 40,
    parameter int unsigned SW        = 26,
    parameter int unsigned DRAIN_CYC = 3
) (
    input  logic          clk_200M,
    input  logic          rst_200M,
    input  logic          start,
    input  logic [SW-1:0] thresh,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    output logic          src_ready,
    output logic [AW-1:0] rec_addr,
    output logic          rec_ce,
    output logic          rec_we,
    output logic [DW-1:0] rec_d,
    input  logic [SW-1:0] sum_in,
    output logic          res_valid,
    output logic [SW-1:0] res_sum,
    output logic          res_motion,
    output logic [15:0]   res_frame,
    input  logic          res_ack,
    output logic          busy
);

    localparam int unsigned DCW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
    localparam logic [AW-1:0]  LAST_ADDR  = AW'(FRAME_LEN - 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYC);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain,
        StReport
    } state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  cnt_q;
    logic [DCW-1:0] drain_q;
    logic [SW-1:0]  thresh_q;
    logic           beat;
    logic           last_beat;
    logic           drain_done;
    logic           report_en;

`ifdef SAD_FIRST_FRAME_MASK_EN
    // Set once the first frame after reset has been captured; until then the datapath
    // memory holds no previous frame, so that result is not reported.
    logic first_done_q;

    always_ff @(posedge clk_200M or posedge rst_200M) begin
        if (rst_200M) begin
            first_done_q <= 1'b0;
        end else if (drain_done) begin
            first_done_q <= 1'b1;
        end
    end

    assign report_en = first_done_q;
`else
    assign report_en = 1'b1;
`endif

    assign src_ready  = (state_q == StScan);
    assign busy       = (state_q != StIdle);
    assign res_valid  = (state_q == StReport);
    assign beat       = src_valid & src_ready;
    assign last_beat  = beat && (cnt_q == LAST_ADDR);
    // DRAIN lasts DRAIN_CYC+1 cycles so the sum is sampled DRAIN_CYC cycles after the last write lands.
    assign drain_done = (state_q == StDrain) && (drain_q == DRAIN_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (last_beat) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (drain_done) begin
                    state_d = report_en ? StReport : StIdle;
                end
            end
            StReport: begin
                if (res_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_200M or posedge rst_200M) begin
        if (rst_200M) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_200M or posedge rst_200M) begin
        if (rst_200M) begin
            cnt_q    <= '0;
            thresh_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            cnt_q    <= '0;
            thresh_q <= thresh;
        end else if (beat && !last_beat) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_200M or posedge rst_200M) begin
        if (rst_200M) begin
            drain_q <= '0;
        end else if (state_q != StDrain) begin
            drain_q <= '0;
        end else if (!drain_done) begin
            drain_q <= drain_q + 1'b1;
        end
    end

    // Address and data hold between beats: the datapath clears its sum on address 0.
    always_ff @(posedge clk_200M or posedge rst_200M) begin
        if (rst_200M) begin
            rec_addr <= '0;
            rec_d    <= '0;
            rec_ce   <= 1'b0;
            rec_we   <= 1'b0;
        end else begin
            rec_ce <= beat;
            rec_we <= beat;
            if (beat) begin
                rec_addr <= cnt_q;
                rec_d    <= src_data;
            end
        end
    end

    always_ff @(posedge clk_200M or posedge rst_200M) begin
        if (rst_200M) begin
            res_sum    <= '0;
            res_motion <= 1'b0;
            res_frame  <= '0;
        end else if (drain_done) begin
            res_sum    <= sum_in;
            res_motion <= (sum_in > thresh_q);
            res_frame  <= res_frame + 16'd1;
        end
    end

endmodule

// File: tb/tb_proc_sad_frame_ctrl.sv
// Scoreboard bench for proc_sad_frame_ctrl: expected writes/results queued at stimulus time,
// popped and compared by monitors when the DUT presents them.
module tb_proc_sad_frame_ctrl;

    localparam int unsigned FL = 8;
    localparam int unsigned AW = 15;
    localparam int unsigned DW = 40;
    localparam int unsigned SW = 26;
    localparam int unsigned DC = 3;

    logic          clk_200M = 1'b0;
    logic          rst_200M = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] thresh = '0;
    logic          src_valid = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          src_ready;
    logic [AW-1:0] rec_addr;
    logic          rec_ce;
    logic          rec_we;
    logic [DW-1:0] rec_d;
    logic [SW-1:0] sum_in = '0;
    logic          res_valid;
    logic [SW-1:0] res_sum;
    logic          res_motion;
    logic [15:0]   res_frame;
    logic          res_ack = 1'b0;
    logic          busy;

    proc_sad_frame_ctrl #(
        .FRAME_LEN(FL),
        .AW       (AW),
        .DW       (DW),
        .SW       (SW),
        .DRAIN_CYC(DC)
    ) dut (
        .clk_200M  (clk_200M),
        .rst_200M  (rst_200M),
        .start     (start),
        .thresh    (thresh),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .rec_addr  (rec_addr),
        .rec_ce    (rec_ce),
        .rec_we    (rec_we),
        .rec_d     (rec_d),
        .sum_in    (sum_in),
        .res_valid (res_valid),
        .res_sum   (res_sum),
        .res_motion(res_motion),
        .res_frame (res_frame),
        .res_ack   (res_ack),
        .busy      (busy)
    );

    initial forever #5 clk_200M = ~clk_200M;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rec_t;

    typedef struct packed {
        logic [SW-1:0] sum;
        logic          motion;
        logic [15:0]   frame;
    } res_t;

    rec_t        rec_q[$];
    res_t        res_q[$];
    int          errors = 0;
    int          checks = 0;
    int          frames_done = 0;
    logic [15:0] frame_model = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every rec_we must match the next queued address/data; idle cycles must hold.
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_d = '0;
    always @(posedge clk_200M) begin
        rec_t e;
        #1;
        if (!rst_200M) begin
            if (rec_we) begin
                if (rec_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rec_unexpected: write at addr %0h with empty queue", rec_addr);
                end else begin
                    e = rec_q.pop_front();
                    chk("rec_addr", 64'(rec_addr), 64'(e.addr));
                    chk("rec_d", 64'(rec_d), 64'(e.data));
                    chk("rec_ce", 64'(rec_ce), 64'd1);
                end
            end else begin
                chk("rec_ce_idle", 64'(rec_ce), 64'd0);
                chk("rec_addr_hold", 64'(rec_addr), 64'(prev_addr));
                chk("rec_d_hold", 64'(rec_d), 64'(prev_d));
            end
        end
        prev_addr = rec_addr;
        prev_d    = rec_d;
    end

    // Result monitor: compare on each rising res_valid.
    logic rv_prev = 1'b0;
    always @(posedge clk_200M) begin
        res_t r;
        #1;
        if (rst_200M) begin
            rv_prev = 1'b0;
        end else begin
            if (res_valid && !rv_prev) begin
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL res_unexpected: res_valid with sum %0d and empty queue", res_sum);
                end else begin
                    r = res_q.pop_front();
                    chk("res_sum", 64'(res_sum), 64'(r.sum));
                    chk("res_motion", 64'(res_motion), 64'(r.motion));
                    chk("res_frame", 64'(res_frame), 64'(r.frame));
                end
            end
            rv_prev = res_valid;
        end
    end

    task automatic feed(input logic [DW-1:0] w[FL], input bit toggle, input bit pulse_start,
                        input int stop_at);
        int  k = 0;
        int  cyc = 0;
        bit  v;
        @(negedge clk_200M);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("src_ready_after_start", 64'(src_ready), 64'd1);
        while (k < stop_at && cyc < 64) begin
            v         = toggle ? (cyc % 2 == 0) : 1'b1;
            src_valid = v;
            src_data  = w[k];
            start     = pulse_start && (cyc == 3);
            if (v && src_ready) k++;
            cyc++;
            @(negedge clk_200M);
        end
        if (cyc >= 64) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: %0d beats accepted", k);
        end
        start = 1'b0;
        if (stop_at == FL) begin
            src_valid = 1'b0;
            chk("src_ready_after_last", 64'(src_ready), 64'd0);
        end
    endtask

    task automatic do_frame(input bit toggle, input logic [SW-1:0] sum, input logic [SW-1:0] thr,
                            input int ack_delay, input bit pulse_start, input int exp_lat);
        logic [DW-1:0] w[FL];
        bit            reports;
        int            lat = 0;
        bit            done = 0;
        for (int i = 0; i < FL; i++) begin
            w[i] = DW'(i) * 40'h0101010101 + DW'(sum);
            rec_q.push_back('{addr: AW'(i), data: w[i]});
        end
`ifdef SAD_FIRST_FRAME_MASK_EN
        reports = (frames_done != 0);
`else
        reports = 1'b1;
`endif
        frame_model = frame_model + 16'd1;
        frames_done++;
        if (reports) res_q.push_back('{sum: sum, motion: (sum > thr), frame: frame_model});

        @(negedge clk_200M);
        start  = 1'b1;
        thresh = thr;
        sum_in = sum;
        fork
            feed(w, toggle, pulse_start, FL);
            begin
                while (!done && lat < 100) begin
                    @(posedge clk_200M);
                    #1;
                    lat++;
                    if (res_valid || (lat > 2 && !busy)) done = 1;
                end
            end
        join
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: no result after %0d cycles", lat);
        end
        if (reports) begin
            if (exp_lat > 0) chk("res_latency", 64'(lat), 64'(exp_lat));
            chk("res_valid_up", 64'(res_valid), 64'd1);
            for (int i = 0; i < ack_delay; i++) begin
                @(negedge clk_200M);
                start = pulse_start && (i == 2);
                chk("res_valid_hold", 64'(res_valid), 64'd1);
                chk("rec_addr_report", 64'(rec_addr), 64'(FL - 1));
            end
            @(negedge clk_200M);
            res_ack = 1'b1;
            start   = pulse_start;
            @(negedge clk_200M);
            res_ack = 1'b0;
            start   = 1'b0;
            chk("res_valid_after_ack", 64'(res_valid), 64'd0);
        end else begin
            chk("masked_no_valid", 64'(res_valid), 64'd0);
            @(negedge clk_200M);
        end
        chk("busy_idle", 64'(busy), 64'd0);
        chk("res_frame_held", 64'(res_frame), 64'(frame_model));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rec_addr"}, 64'(rec_addr), 64'd0);
        chk({tag, "_rec_ce"}, 64'(rec_ce), 64'd0);
        chk({tag, "_rec_we"}, 64'(rec_we), 64'd0);
        chk({tag, "_rec_d"}, 64'(rec_d), 64'd0);
        chk({tag, "_src_ready"}, 64'(src_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_res_sum"}, 64'(res_sum), 64'd0);
        chk({tag, "_res_motion"}, 64'(res_motion), 64'd0);
        chk({tag, "_res_frame"}, 64'(res_frame), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] w[FL];
        #12;
        chk_all_zero("reset");
        @(negedge clk_200M);
        rst_200M = 1'b0;
        @(negedge clk_200M);
        chk_all_zero("post_reset");

        do_frame(1'b0, SW'(150), SW'(100), 0, 1'b0, 13);
        do_frame(1'b0, SW'(100), SW'(100), 0, 1'b0, 13);
        do_frame(1'b1, SW'(99), SW'(100), 5, 1'b1, 0);

        // Abort a frame after four beats with an asynchronous reset.
        for (int i = 0; i < FL; i++) w[i] = DW'(i) * 40'h0303030303 + 40'h11;
        for (int i = 0; i < 4; i++) rec_q.push_back('{addr: AW'(i), data: w[i]});
        @(negedge clk_200M);
        start  = 1'b1;
        thresh = SW'(10);
        sum_in = SW'(777);
        feed(w, 1'b0, 1'b0, 4);
        rst_200M = 1'b1;
        #1;
        chk_all_zero("async_reset");
        src_valid   = 1'b0;
        frame_model = '0;
        frames_done = 0;
        rec_q.delete();
        @(negedge clk_200M);
        rst_200M = 1'b0;
        @(negedge clk_200M);
        chk("res_frame_after_abort", 64'(res_frame), 64'd0);

        do_frame(1'b0, SW'(500), SW'(10), 1, 1'b0, 13);
`ifdef SAD_FIRST_FRAME_MASK_EN
        do_frame(1'b0, SW'(5), SW'(10), 0, 1'b0, 13);
`endif

        repeat (4) @(negedge clk_200M);
        chk("rec_queue_drained", 64'(rec_q.size()), 64'd0);
        chk("res_queue_drained", 64'(res_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/proc_sad_frame_ctrl.md
# proc_sad_frame_ctrl

Frame sequencer for the SAD (sum-of-absolute-differences) subtraction datapath.
- Accepts one frame of 40-bit pixel words (5 × 8-bit lanes) from an upstream source over a valid/ready handshake.
- Drives the datapath's address, chip-enable, write-enable and data inputs in address order 0..FRAME_LEN-1.
- Waits for the datapath pipeline to drain, then samples the accumulated sum.
- Presents the sum, a motion flag and a frame count downstream under a valid/ack handshake.
- Sits between the pixel capture path and the motion-detect logic.

## Interface
Parameters:
- FRAME_LEN, 18000: words per frame; addresses 0..FRAME_LEN-1.
- AW, 15: address width.
- DW, 40: pixel word width.
- SW, 26: sum width.
- DRAIN_CYC, 3: cycles from last issued word until the datapath sum is final.

Ports:
- clk_200M  in  1  clock, rising-edge.
- rst_200M  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle frame request; honoured only in IDLE.
- thresh  in  SW  motion threshold; sampled on accepted start.
- src_valid  in  1  upstream word valid.
- src_data  in  DW  upstream word.
- src_ready  out  1  controller can accept a word.
- rec_addr  out  AW  datapath address.
- rec_ce  out  1  datapath chip enable.
- rec_we  out  1  datapath write enable.
- rec_d  out  DW  datapath data.
- sum_in  in  SW  datapath accumulated sum.
- res_valid  out  1  result available.
- res_sum  out  SW  captured frame sum.
- res_motion  out  1  res_sum > captured thresh.
- res_frame  out  16  count of completed frames; wraps 0xFFFF→0.
- res_ack  in  1  downstream consumes result.
- busy  out  1  state ≠ IDLE.

## Operation
- States:
  - IDLE: start → SCAN; beat counter cleared; thresh latched.
  - SCAN: src_ready=1. Each beat (src_valid & src_ready) issues one word. The beat with counter = FRAME_LEN-1 → DRAIN.
  - DRAIN: counts DRAIN_CYC cycles, then → REPORT. On entry to REPORT, capture sum_in into res_sum, compute res_motion, increment res_frame.
  - REPORT: res_valid=1 until res_ack → IDLE.
- Issued word: rec_addr=counter, rec_d=src_data, rec_ce=rec_we=1, all registered.
- No beat: rec_ce=rec_we=0; rec_addr and rec_d hold their values.
- rec_addr holds its last value after the frame until the next frame's first beat. The datapath clears its sum when the address is 0, so rec_addr must not return to 0 early.
- res_sum, res_motion and res_frame hold their values until the next capture.
- start is ignored outside IDLE. res_ack is ignored outside REPORT.
- Comparison is unsigned SW-bit; equal to thresh → res_motion=0.
- Counter is AW bits and never exceeds FRAME_LEN-1.

## Timing
- Reset values:
  - State = IDLE.
  - Counter = 0.
  - rec_addr = 0, rec_ce = 0, rec_we = 0, rec_d = 0.
  - src_ready = 0, busy = 0.
  - res_valid = 0, res_sum = 0, res_motion = 0, res_frame = 0.
  - Latched thresh = 0.
- start in cycle N:
  - busy=1 and src_ready=1 in N+1.
  - A beat in cycle M puts rec_* valid in M+1.
- Last beat in cycle L:
  - src_ready=0 from L+1.
  - Sum captured at edge L+1+DRAIN_CYC.
  - res_valid=1 from cycle L+2+DRAIN_CYC.
- Minimum frame period = FRAME_LEN + DRAIN_CYC + 3 cycles with src_valid held high and res_ack held high.
- res_ack in the same cycle res_valid rises completes the handshake. res_valid=0 next cycle, state IDLE.
- start in the same cycle as the res_ack that ends REPORT is ignored.
- Reset asserted mid-frame: everything returns to reset values immediately. A partial frame produces no result and res_frame does not increment.

## Configuration
- SAD_FIRST_FRAME_MASK_EN defined:
  - The first completed frame after reset still scans, drains and increments res_frame.
  - It does not assert res_valid (datapath memory holds no previous frame). REPORT is skipped straight to IDLE.
  - res_sum is still captured.
- Undefined: every frame, including the first, reports.

## Test plan
- Bench parameters: FRAME_LEN=8, DRAIN_CYC=3.
- Reset, then start, thresh=100, src_valid held high, data 0 → exactly 8 rec_we pulses at addresses 0..7. res_valid rises 13 cycles after start. Drive sum_in=150 → res_sum=150, res_motion=1, res_frame=1.
- Same frame with sum_in=100 → res_motion=0 (equal is not greater).
- src_valid toggled 1,0,1,0... → rec_ce low on stall cycles, rec_addr held, addresses still 0..7 with no gaps or repeats. After the frame, rec_addr stays 7 through REPORT.
- start pulsed during SCAN and REPORT → ignored; res_ack delayed 5 cycles → res_valid held, then IDLE.
- Reset asserted at beat 4 → all outputs return to 0 asynchronously. A fresh start scans from address 0. res_frame still 0 until that frame completes.
- With SAD_FIRST_FRAME_MASK_EN: first frame → no res_valid, res_frame=1. Second frame → res_valid, res_frame=2.
